gsim_param: RTL and testbench
=============================

# gsim_param

Parametrised Gauss-Seidel solver for the fixed banded system 20·x[i] − 13·(x[i−1]+x[i+1]) + 6·(x[i−2]+x[i+2]) − (x[i−3]+x[i+3]) = b[i], i = 0..N−1.
- Successor to the fixed 16-point solver, generalised in problem size, word widths and sweep count.
- Adds ready/valid backpressure on both sides and a busy/status interface.
- Sits between the host b-vector loader and the result collector; one problem in flight at a time.

## Interface
- N, 16: system size, 4..64.
- BW, 16: signed integer width of b.
- XW, 32: signed width of x, fixed point with FRAC fraction bits.
- FRAC, 16: fraction bits of x.
- IW, 6: width of sweep-count config.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_en  in  1  b_in valid.
- b_in  in  BW  signed b[i], sent in order i = 0..N−1.
- in_ready  out  1  high in RECV; a beat is accepted when in_en && in_ready.
- iter_cfg  in  IW  number of sweeps; sampled on the first accepted beat; 0 is treated as 1.
- out_valid  out  1  x_out holds a valid result.
- out_ready  in  1  consumer accepts x_out when out_valid && out_ready.
- x_out  out  XW  signed x[i], sent in order i = 0..N−1.
- busy  out  1  high in CALC and SEND.
- iter_used  out  IW  sweeps actually performed for the current or last problem.

## Operation
- States: RECV, CALC, SEND. Reset enters RECV with idx=0, sweep=0, and all x and b cleared.
- RECV: each accepted beat writes b[idx] and increments idx. On acceptance of beat N−1:
  - idx returns to 0;
  - every x[i] is cleared to 0 (initial guess);
  - the state moves to CALC.
- CALC: one element updated per cycle, in place, i = idx:
  - S = (b[i] << FRAC) + 13·(x[i−1]+x[i+1]) − 6·(x[i−2]+x[i+2]) + (x[i−3]+x[i+3]).
  - Out-of-range neighbours contribute 0.
  - Lower neighbours have already been updated this sweep; upper neighbours hold the previous sweep's values.
  - S is computed signed at XW+8 bits.
  - Division by 20: q = (S·52429) >>> 20, arithmetic shift, i.e. floor.
  - q is saturated to the signed XW range and written to x[i].
  - idx wraps at N−1 and sweep increments on wrap. After the final sweep wraps, the state moves to SEND with idx=0.
- SEND: x_out = x[idx] (combinational mux from the registered idx).
  - Each handshake increments idx.
  - After the handshake at idx = N−1, the state moves to RECV and idx=0.
  - x_out is held stable while out_valid && !out_ready.
- iter_used is cleared on the first beat of a new problem, counts completed sweeps, and holds its value through SEND and the following RECV.

## Timing
- Reset values:
  - in_ready = 1 (RECV);
  - out_valid = 0;
  - busy = 0;
  - x_out = 0 (x[0] cleared);
  - iter_used = 0.
- Input: at most one beat per cycle. in_ready drops the cycle after beat N−1 is accepted. in_en outside RECV is ignored.
- CALC latency: exactly max(iter_cfg,1)·N cycles. out_valid rises on the next cycle after the final update.
- Output: with out_ready held at 1, SEND lasts N cycles. in_ready rises the cycle after the last handshake.
- Reset asserted mid-CALC or mid-SEND aborts the problem immediately. After release, the block is in RECV and in_ready = 1 with no output.
- Simultaneous out_ready on the last word and in_en: the input beat is not accepted in that cycle (in_ready is still 0).

## Configuration
- GSIM_EARLY_EXIT_EN defined:
  - Track whether any x[i] changed value during the current sweep.
  - If a full sweep completes with no change, go to SEND immediately, even if sweeps remain.
  - iter_used reports the sweeps actually performed, including the unchanged one.
- GSIM_EARLY_EXIT_EN undefined:
  - Exactly max(iter_cfg,1) sweeps always run.
  - iter_used equals max(iter_cfg,1) at SEND.

## Test plan
- N=4, iter_cfg=1, b = {1,0,0,0} -> x_out = 3276, 2129, then x[2], x[3] per the reference model; out_valid exactly 4 cycles after the last input beat.
- N=4, iter_cfg=1, b = {−1,0,0,0} -> x[0] = −3277 (floor rounding check).
- N=16, iter_cfg=16, all b = 0 -> 16 zeros out.
  - Macro off: iter_used = 16, CALC = 256 cycles.
  - Macro on: iter_used = 1, CALC = 16 cycles.
- N=16, random b, iter_cfg=20, out_ready toggled 0/1 randomly -> all 16 words match the bit-exact model, x_out stable while stalled, in_ready = 0 until the last handshake.
- Reset pulsed at CALC cycle 100 -> out_valid never asserts; after release, a fresh problem with b = {1,0,...} gives the same result as a clean run.
- iter_cfg = 0 -> behaves as 1 sweep, iter_used = 1; in_en held high through CALC and SEND -> no extra beats captured.

Source files
------------

// File: rtl/gsim_param.sv
// rtl/gsim_param.sv - parametrised Gauss-Seidel solver for the 7-band system, one problem in flight.
// Optional feature: define GSIM_EARLY_EXIT_EN to stop after the first sweep that changes no x[i].
module gsim_param #(
  parameter int N    = 16,
  parameter int BW   = 16,
  parameter int XW   = 32,
  parameter int FRAC = 16,
  parameter int IW   = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_en,
  input  logic signed [BW-1:0] b_in,
  output logic                 in_ready,
  input  logic [IW-1:0]        iter_cfg,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [XW-1:0] x_out,
  output logic                 busy,
  output logic [IW-1:0]        iter_used
);

  localparam int IDXW = $clog2(N);
  localparam int SW   = XW + 8;
  localparam int PW   = SW + 17;
  localparam int PIW  = $clog2(N + 6);

  localparam logic signed [SW-1:0] C13      = 13;
  localparam logic signed [SW-1:0] C6       = 6;
  localparam logic signed [PW-1:0] C_RECIP  = 52429;
  localparam logic signed [PW-1:0] XMAX     = {{(PW-XW+1){1'b0}}, {(XW-1){1'b1}}};
  localparam logic signed [PW-1:0] XMIN     = {{(PW-XW+1){1'b1}}, {(XW-1){1'b0}}};

  typedef enum logic [1:0] {RECV, CALC, SEND} state_t;

  state_t                r_state;
  logic [IDXW-1:0]       r_idx;
  logic [IW-1:0]         r_sweep;
  logic [IW-1:0]         r_tgt;
  logic [IW-1:0]         r_iter_used;
  logic                  r_changed;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic                  r_busy;
  logic signed [BW-1:0]  r_b [N];
  logic signed [XW-1:0]  r_x [N];

  logic signed [SW-1:0]  w_xp [N+6];
  logic [PIW-1:0]        w_pi;
  logic signed [SW-1:0]  w_bs;
  logic signed [SW-1:0]  w_sum;
  logic signed [PW-1:0]  w_prod;
  logic signed [PW-1:0]  w_q;
  logic signed [XW-1:0]  w_qs;
  logic                  w_last;
  logic [IW:0]           w_sweep_nx;
  logic                  w_done_all;
  logic                  w_chg;
  logic                  w_stop;

  // x padded with three zeros on each side so out-of-range neighbours read as 0
  for (genvar g = 0; g < N + 6; g++) begin : gen_pad
    if (g >= 3 && g < N + 3) begin : g_x
      assign w_xp[g] = SW'(r_x[g-3]);
    end else begin : g_z
      assign w_xp[g] = '0;
    end
  end

  assign w_pi   = PIW'(r_idx) + PIW'(3);
  assign w_bs   = SW'(r_b[r_idx]) <<< FRAC;
  assign w_sum  = w_bs
                + C13 * (w_xp[w_pi - PIW'(1)] + w_xp[w_pi + PIW'(1)])
                - C6  * (w_xp[w_pi - PIW'(2)] + w_xp[w_pi + PIW'(2)])
                +       (w_xp[w_pi - PIW'(3)] + w_xp[w_pi + PIW'(3)]);
  // floor(S/20) via reciprocal multiply and arithmetic shift
  assign w_prod = PW'(w_sum) * C_RECIP;
  assign w_q    = w_prod >>> 20;
  assign w_qs   = (w_q > XMAX) ? XMAX[XW-1:0] :
                  (w_q < XMIN) ? XMIN[XW-1:0] : w_q[XW-1:0];

  assign w_last     = (r_idx == IDXW'(N - 1));
  assign w_sweep_nx = {1'b0, r_sweep} + 1'b1;
  assign w_done_all = (w_sweep_nx >= {1'b0, r_tgt});
  assign w_chg      = r_changed || (w_qs != r_x[r_idx]);
`ifdef GSIM_EARLY_EXIT_EN
  assign w_stop     = w_done_all || !w_chg;
`else
  assign w_stop     = w_done_all;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= RECV;
      r_idx       <= '0;
      r_sweep     <= '0;
      r_tgt       <= IW'(1);
      r_iter_used <= '0;
      r_changed   <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      for (int k = 0; k < N; k++) begin
        r_b[k] <= '0;
        r_x[k] <= '0;
      end
    end else begin
      case (r_state)
        RECV: begin
          if (in_en) begin
            r_b[r_idx] <= b_in;
            if (r_idx == '0) begin
              r_tgt       <= (iter_cfg == '0) ? IW'(1) : iter_cfg;
              r_iter_used <= '0;
            end
            if (w_last) begin
              r_idx      <= '0;
              r_sweep    <= '0;
              r_changed  <= 1'b0;
              for (int k = 0; k < N; k++) r_x[k] <= '0;
              r_state    <= CALC;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b1;
            end else begin
              r_idx <= r_idx + IDXW'(1);
            end
          end
        end
        CALC: begin
          r_x[r_idx] <= w_qs;
          r_changed  <= w_chg;
          if (w_last) begin
            r_idx       <= '0;
            r_sweep     <= w_sweep_nx[IW-1:0];
            r_iter_used <= w_sweep_nx[IW-1:0];
            r_changed   <= 1'b0;
            if (w_stop) begin
              r_state     <= SEND;
              r_out_valid <= 1'b1;
            end
          end else begin
            r_idx <= r_idx + IDXW'(1);
          end
        end
        SEND: begin
          if (out_ready) begin
            if (w_last) begin
              r_idx       <= '0;
              r_state     <= RECV;
              r_out_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_in_ready  <= 1'b1;
            end else begin
              r_idx <= r_idx + IDXW'(1);
            end
          end
        end
        default: r_state <= RECV;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign iter_used = r_iter_used;
  assign x_out     = r_x[r_idx];

endmodule

// File: tb/tb_gsim_param.sv
// tb/tb_gsim_param.sv - randomized bench for gsim_param against an arithmetic Gauss-Seidel model.
module tb_gsim_param;
  localparam int N = 16, BW = 16, XW = 32, FRAC = 16, IW = 6;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_en;
  logic signed [BW-1:0] b_in;
  logic                 in_ready;
  logic [IW-1:0]        iter_cfg;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [XW-1:0] x_out;
  logic                 busy;
  logic [IW-1:0]        iter_used;

  gsim_param #(.N(N), .BW(BW), .XW(XW), .FRAC(FRAC), .IW(IW)) dut (
    .clk(clk), .reset(reset), .in_en(in_en), .b_in(b_in), .in_ready(in_ready),
    .iter_cfg(iter_cfg), .out_valid(out_valid), .out_ready(out_ready),
    .x_out(x_out), .busy(busy), .iter_used(iter_used)
  );

  always #5 clk = ~clk;

  int     n_chk = 0, n_err = 0;
  int     tb_b [N];
  longint exp_x [N];
  longint got_x [N];
  int     exp_used;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint xat(input int k);
    if (k < 0 || k >= N) return 0;
    return exp_x[k];
  endfunction

  // Direct evaluation of the iteration rules in 64-bit arithmetic
  task automatic model(input int cfg);
    int     sweeps;
    longint s, q;
    bit     changed;
    sweeps = (cfg == 0) ? 1 : cfg;
    for (int k = 0; k < N; k++) exp_x[k] = 0;
    exp_used = 0;
    for (int sw = 0; sw < sweeps; sw++) begin
      changed = 0;
      for (int i = 0; i < N; i++) begin
        s = longint'(tb_b[i]) * (longint'(1) << FRAC)
          + 13 * (xat(i-1) + xat(i+1)) - 6 * (xat(i-2) + xat(i+2)) + (xat(i-3) + xat(i+3));
        q = (s * 52429) >>> 20;
        if (q > 64'sd2147483647) q = 64'sd2147483647;
        if (q < -64'sd2147483648) q = -64'sd2147483648;
        if (q != exp_x[i]) changed = 1;
        exp_x[i] = q;
      end
      exp_used++;
`ifdef GSIM_EARLY_EXIT_EN
      if (!changed) break;
`endif
    end
  endtask

  task automatic load(input int cfg, input bit hold_en);
    int i = 0, guard = 0;
    bit acc;
    iter_cfg = IW'(cfg);
    while (i < N && guard < 200) begin
      in_en = 1'b1;
      b_in  = BW'(tb_b[i]);
      acc   = in_ready;
      @(posedge clk); #1;
      if (acc) i++;
      guard++;
    end
    chk("load_beats", i, N);
    in_en    = hold_en;
    b_in     = BW'($urandom);
    iter_cfg = IW'($urandom);
    chk("in_ready_drop", in_ready, 0);
  endtask

  task automatic wait_calc(input string tag);
    int cyc = 0;
    while (!out_valid && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_latency"}, cyc, exp_used * N);
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_iter_used"}, iter_used, exp_used);
  endtask

  task automatic receive(input string tag, input bit stall);
    int w = 0, guard = 0;
    logic signed [XW-1:0] prev = '0;
    bit prev_stall = 0;
    while (w < N && guard < 300) begin
      out_ready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (out_valid) begin
        chk({tag, "_x_out"}, x_out, exp_x[w]);
        if (prev_stall) chk({tag, "_stable"}, x_out, prev);
        chk({tag, "_in_ready_send"}, in_ready, 0);
        prev       = x_out;
        prev_stall = !out_ready;
        if (out_ready) begin
          got_x[w] = x_out;
          w++;
        end
      end else begin
        chk({tag, "_out_valid_held"}, out_valid, 1);
      end
      @(posedge clk); #1;
      guard++;
    end
    out_ready = 1'b0;
    chk({tag, "_words"}, w, N);
    if (!stall) chk({tag, "_send_cycles"}, guard, N);
    chk({tag, "_out_valid_end"}, out_valid, 0);
    chk({tag, "_in_ready_back"}, in_ready, 1);
    chk({tag, "_iter_used_hold"}, iter_used, exp_used);
  endtask

  task automatic run(input string tag, input int cfg, input bit stall);
    model(cfg);
    load(cfg, 1'b0);
    wait_calc(tag);
    receive(tag, stall);
  endtask

  task automatic rand_b();
    logic signed [BW-1:0] t;
    for (int k = 0; k < N; k++) begin
      t = BW'($urandom);
      tb_b[k] = t;
    end
  endtask

  task automatic unit_b(input int v);
    for (int k = 0; k < N; k++) tb_b[k] = 0;
    tb_b[0] = v;
  endtask

  initial begin
    int seen;
    reset = 1'b1; in_en = 1'b0; out_ready = 1'b0; b_in = '0; iter_cfg = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_x_out", x_out, 0);
    chk("rst_iter_used", iter_used, 0);

    unit_b(1);
    run("unit", 1, 1'b0);
    chk("unit_x0_const", got_x[0], 3276);
    chk("unit_x1_const", got_x[1], 2129);

    unit_b(-1);
    run("neg", 1, 1'b0);
    chk("neg_x0_floor", got_x[0], -3277);

    unit_b(0);
    run("zero", 16, 1'b0);
`ifdef GSIM_EARLY_EXIT_EN
    chk("zero_iter_used_const", iter_used, 1);
`else
    chk("zero_iter_used_const", iter_used, 16);
`endif

    rand_b();
    run("rand20", 20, 1'b1);
    for (int p = 0; p < 3; p++) begin
      rand_b();
      run("rand", $urandom_range(1, 20), 1'b1);
    end

    // abort mid-CALC
    rand_b();
    model(20);
    load(20, 1'b0);
    repeat (100) @(posedge clk);
    #1 reset = 1'b1;
    #1 chk("abort_busy_async", busy, 0);
    @(posedge clk); #1 reset = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_x_out", x_out, 0);
    chk("abort_iter_used", iter_used, 0);
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("abort_no_output", seen, 0);
    unit_b(1);
    run("after_abort", 1, 1'b0);
    chk("after_abort_x0", got_x[0], 3276);

    // iter_cfg 0 with in_en held high through CALC and SEND
    rand_b();
    model(0);
    load(0, 1'b1);
    wait_calc("cfg0");
    chk("cfg0_iter_used_const", iter_used, 1);
    receive("cfg0", 1'b1);
    in_en = 1'b0;
    rand_b();
    run("post_cfg0", 3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
